iterative_alu: RTL and testbench

Multi-cycle ALU directly downstream of the ALU control stage: consumes the 4-bit ALU operation code plus two operands and produces a registered result with a start/done handshake. ADD and OR complete in one cycle; SLL/SRL shift one bit per clock, so area stays small at the cost of variable latency. `busy_o` feeds the datapath stall logic that holds the PC while a shift is in flight.

---
 rtl/iterative_alu_pkg.sv | 23 ++
 rtl/iterative_shifter.sv | 50 +++++
 rtl/iterative_alu.sv | 124 ++++++++++++
 tb/tb_iterative_alu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/iterative_alu_pkg.sv
// Shared definitions for the ALU control stage and the iterative ALU:
// operation codes and the iterative ALU state encoding.
package iterative_alu_pkg;

    // Operation codes produced by ALU control
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_SRL = 4'b0011;

    // Iterative ALU controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_t;

    // True for the op codes that take the multi-cycle shift path
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/iterative_shifter.sv
// One-bit-per-clock shifter: a data register, a down-counter holding the
// remaining shift steps and a latched direction flag.
module iterative_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0]      load_count,
    input  logic                  load_right,
    output logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] step_data,
    output logic                  count_zero
);

    logic [CNT_W-1:0] count;
    logic             right;

    // Value the data register takes on the next step (logical, zero fill)
    always_comb begin
        step_data = '0;
        if (right) begin
            step_data = {1'b0, data[DATA_WIDTH-1:1]};
        end else begin
            step_data = {data[DATA_WIDTH-2:0], 1'b0};
        end
    end

    assign count_zero = (count == '0);

    // Load operand/amount/direction on accept, otherwise shift and count down
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data  <= '0;
            count <= '0;
            right <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            count <= load_count;
            right <= load_right;
        end else if (step) begin
            data  <= step_data;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/iterative_alu.sv
// Multi-cycle ALU: ADD/OR (and unknown ops) finish in one cycle, SLL/SRL
// shift one bit per clock through iterative_shifter.
//
// Handshake: start_i is a request that is taken only on an edge where the
// block is in IDLE or DONE (busy_o low); there is no ready output and no
// queueing, so a request raised while busy_o is high is simply dropped.
// done_o pulses for exactly one cycle and marks result_o/zero_o as valid;
// result_o then holds until the next accepted request.
module iterative_alu
    import iterative_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            state_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    alu_state_t            state;
    logic                  accept;
    logic                  shift_op;
    logic [DATA_WIDTH-1:0] op_result;
    logic                  sh_step;
    logic [DATA_WIDTH-1:0] sh_data;
    logic [DATA_WIDTH-1:0] sh_step_data;
    logic                  sh_count_zero;

    assign accept   = start_i && ((state == ST_IDLE) || (state == ST_DONE));
    assign shift_op = is_shift_op(ALU_Operation_i);
    assign sh_step  = (state == ST_SHIFT) && !sh_count_zero;
    assign state_o  = state;

    // Single-cycle operation result; unknown codes yield zero
    always_comb begin
        op_result = '0;
        case (ALU_Operation_i)
            ALU_ADD: op_result = A_i + B_i;
            ALU_OR:  op_result = A_i | B_i;
            default: op_result = '0;
        endcase
    end

    iterative_shifter #(
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_W     (CNT_W)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && shift_op),
        .step      (sh_step),
        .load_data (A_i),
        .load_count(B_i[CNT_W-1:0]),
        .load_right(ALU_Operation_i == ALU_SRL),
        .data      (sh_data),
        .step_data (sh_step_data),
        .count_zero(sh_count_zero)
    );

    // Controller FSM with registered result, zero flag and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            result_o <= '0;
            zero_o   <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        if (shift_op) begin
                            result_o <= A_i;
                            zero_o   <= (A_i == '0);
                            state    <= ST_SHIFT;
                            busy_o   <= 1'b1;
                            done_o   <= 1'b0;
                        end else begin
                            result_o <= op_result;
                            zero_o   <= (op_result == '0);
                            state    <= ST_DONE;
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                        end
                    end else begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (sh_count_zero) begin
                        state  <= ST_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        // Mirror the shifter so zero_o tracks every step
                        result_o <= sh_step_data;
                        zero_o   <= (sh_step_data == '0);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

    // The shifter copy is only consulted through its step value
    logic unused_sh_data;
    assign unused_sh_data = ^sh_data;

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: directed scenarios plus random
// operations checked against an arithmetic reference model.
module tb_iterative_alu;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start_i;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         busy_o;
  logic         done_o;
  logic [1:0]   state_o;

  int n_tests;
  int n_fail;
  logic [W-1:0] exp_q[$];

  iterative_alu #(.DATA_WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .ALU_Operation_i(op),
    .A_i            (a),
    .B_i            (b),
    .result_o       (result_o),
    .zero_o         (zero_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .state_o        (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic logic [W-1:0] model_result(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int amt;
    amt = int'(y % W);
    case (o)
      4'd0: return x + y;
      4'd1: return x | y;
      4'd2: return x << amt;
      4'd3: return x >> amt;
      default: return '0;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] o, input logic [W-1:0] y);
    if (o == 4'd2 || o == 4'd3) return int'(y % W) + 2;
    return 1;
  endfunction

  // driver: issue one op, wait for done, check result/latency/busy
  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    logic [W-1:0] exp_res;
    int exp_lat;
    int lat;
    int busy_cycles;
    exp_q.push_back(model_result(o, x, y));
    exp_lat = model_latency(o, y);
    @(negedge clk);
    start_i = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start_i = 1'b0;
    op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
    lat = 1;
    busy_cycles = 0;
    while (!done_o && lat < 200) begin
      if (busy_o) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    exp_res = exp_q.pop_front();
    n_tests++;
    if (done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: done_o=%b after %0d cycles, required 1", tag, done_o, lat);
    end else begin
      n_tests += 3;
      if (lat != exp_lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d, required %0d", tag, lat, exp_lat);
      end
      if (result_o !== exp_res) begin
        n_fail++;
        $display("FAIL %s result: got %h, required %h", tag, result_o, exp_res);
      end
      if (zero_o !== (exp_res == '0)) begin
        n_fail++;
        $display("FAIL %s zero: got %b, required %b", tag, zero_o, (exp_res == '0));
      end
      if (exp_lat > 1) begin
        n_tests++;
        if (busy_cycles != exp_lat - 1) begin
          n_fail++;
          $display("FAIL %s busy cycles: got %0d, required %0d", tag, busy_cycles, exp_lat - 1);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests += 4;
    if (result_o !== '0) begin n_fail++; $display("FAIL %s result: got %h, required 0", tag, result_o); end
    if (zero_o !== 1'b1) begin n_fail++; $display("FAIL %s zero: got %b, required 1", tag, zero_o); end
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b, required 0", tag, busy_o); end
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL %s done: got %b, required 0", tag, done_o); end
  endtask

  task automatic test_reset();
    reset = 1'b0; start_i = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("idle_after_reset");
  endtask

  task automatic test_directed();
    do_op(4'b0000, 32'hFFFF_FFFF, 32'h1, "add_wrap");
    repeat (2) @(posedge clk);
    do_op(4'b0001, 32'hF0F0_0000, 32'h0000_0F0F, "or");
    repeat (2) @(posedge clk);
    do_op(4'b0010, 32'h1, 32'h0000_0025, "sll_5");
    do_op(4'b0011, 32'h8000_0000, 32'd31, "srl_31");
    do_op(4'b0011, 32'hDEAD_BEEF, 32'd0, "srl_0");
    do_op(4'b0111, 32'h1234_5678, 32'h9ABC_DEF0, "unknown_op");
    do_op(4'b0010, 32'h8000_0001, 32'd1, "sll_msb_out");
  endtask

  task automatic test_shift_ignore();
    int lat;
    @(negedge clk);
    start_i = 1'b1; op = 4'b0010; a = 32'h3; b = 32'd4;
    @(posedge clk); #1;
    lat = 1;
    // competing ADD requests while shifting must be dropped
    op = 4'b0000; a = 32'h1111_1111; b = 32'h2222_2222;
    repeat (2) begin @(posedge clk); #1; lat++; end
    start_i = 1'b0;
    while (!done_o && lat < 100) begin @(posedge clk); #1; lat++; end
    n_tests += 2;
    if (lat != 6) begin n_fail++; $display("FAIL shift_ignore latency: got %0d, required 6", lat); end
    if (result_o !== 32'h30) begin n_fail++; $display("FAIL shift_ignore result: got %h, required 00000030", result_o); end
    // start in the DONE cycle: ADD accepted, done one cycle later
    do_op(4'b0000, 32'd100, 32'd23, "add_in_done");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [3:0]   o;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      o = 4'($urandom_range(0, 1));
      x = $urandom; y = $urandom;
      exp_q.push_back(model_result(o, x, y));
      @(negedge clk);
      start_i = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      n_tests += 2;
      if (done_o !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] done: got %b, required 1", i, done_o); end
      if (result_o !== exp_q[0]) begin n_fail++; $display("FAIL b2b[%0d] result: got %h, required %h", i, result_o, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    @(negedge clk); start_i = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    bit seen_done;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start_i = 1'b1; op = 4'b0010; a = 32'h1; b = 32'd20;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid_shift");
    @(negedge clk); reset = 1'b1;
    seen_done = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done_o) seen_done = 1'b1;
    end
    n_tests++;
    if (seen_done) begin n_fail++; $display("FAIL reset_mid_shift stray done: got 1, required 0"); end
  endtask

  task automatic test_random();
    logic [3:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: o = 4'b0000;
        1: o = 4'b0001;
        2: o = 4'b0010;
        3: o = 4'b0011;
        default: o = 4'($urandom_range(4, 15));
      endcase
      x = $urandom; y = $urandom;
      if ($urandom_range(0, 7) == 0) x = '0;
      do_op(o, x, y, $sformatf("rand[%0d]", i));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_shift_ignore();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
